// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT FSM.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'h0000007F,
    parameter logic [31:0] NOP_WORD  = 32'h00000033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        ifid_valid_next;
    logic [31:0] ifid_pc_next;
    logic [31:0] ifid_pc4_next;
    logic [31:0] ifid_inst_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_inst  <= NOP_WORD;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_valid <= ifid_valid_next;
            ifid_pc    <= ifid_pc_next;
            ifid_pc4   <= ifid_pc4_next;
            ifid_inst  <= ifid_inst_next;
        end
    end

    // Redirect outranks stall and halt detection; a fetched halt word is squashed to a bubble.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        ifid_valid_next = ifid_valid;
        ifid_pc_next    = ifid_pc;
        ifid_pc4_next   = ifid_pc4;
        ifid_inst_next  = ifid_inst;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_next         = redirect_pc & 32'hFFFF_FFFC;
                    ifid_valid_next = 1'b0;
                    ifid_inst_next  = NOP_WORD;
                end else if (!stall) begin
                    if (inst_in == HALT_WORD) begin
                        state_next      = HALT;
                        ifid_valid_next = 1'b0;
                        ifid_inst_next  = NOP_WORD;
                    end else begin
                        pc_next         = pc + 32'd4;
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = pc;
                        ifid_pc4_next   = pc + 32'd4;
                        ifid_inst_next  = inst_in;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
        endcase
    end

    assign pc_out = pc;
    assign halted = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic        count_en;
    logic [31:0] count;

    assign count_en = (state == RUN) && !redirect_valid && !stall && (inst_in != HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'h0;
        end else if (count_en) begin
            count <= count + 32'd1;
        end
    end

    assign fetch_count = count;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, a spec-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h00000000;
    localparam logic [31:0] HALT_WORD = 32'h0000007F;
    localparam logic [31:0] NOP_WORD  = 32'h00000033;
    localparam logic [31:0] ADDI      = 32'h00600513;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst_in = 32'h0;
    logic [31:0] pc_out;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        halted;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: what the outputs must be after the most recent edge.
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_inst;
    logic [31:0] m_fetches;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .HALT_WORD(HALT_WORD),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_in       (inst_in),
        .pc_out        (pc_out),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_inst     (ifid_inst),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Applies one cycle of inputs and advances the model by the rules for that cycle.
    task automatic apply_stimulus(input logic r, input logic s, input logic rv,
                                  input logic [31:0] rpc, input logic [31:0] inst);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_in        = inst;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_halted = 1'b0; m_valid = 1'b0;
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = NOP_WORD; m_fetches = 32'h0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_inst = NOP_WORD;
        end else if (s) begin
            // hold
        end else if (inst == HALT_WORD) begin
            m_halted = 1'b1; m_valid = 1'b0; m_inst = NOP_WORD;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = inst; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_fetches = m_fetches + 32'd1;
        end
        check_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("pc_out", pc_out, m_pc);
            check_output("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            check_output("ifid_pc", ifid_pc, m_ipc);
            check_output("ifid_pc4", ifid_pc4, m_ipc4);
            check_output("ifid_inst", ifid_inst, m_inst);
            check_output("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef FETCH_PERF_CNT_EN
            check_output("fetch_count", fetch_count, m_fetches);
`else
            check_output("fetch_count", fetch_count, 32'h0);
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(negedge clk);
        // Reset state
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("lit reset pc", pc_out, 32'h0);
        check_output("lit reset inst", ifid_inst, 32'h00000033);

        // Sequential fetch, stall at pc 8, release
        apply_stimulus(0, 0, 0, 0, ADDI);
        check_output("lit c1 pc", pc_out, 32'h4);
        check_output("lit c1 ifid_pc4", ifid_pc4, 32'h4);
        apply_stimulus(0, 0, 0, 0, ADDI);
        check_output("lit c2 pc", pc_out, 32'h8);
        apply_stimulus(0, 1, 0, 0, ADDI);
        apply_stimulus(0, 1, 0, 0, ADDI);
        check_output("lit stall pc", pc_out, 32'h8);
        check_output("lit stall ifid_pc", ifid_pc, 32'h4);
        apply_stimulus(0, 0, 0, 0, ADDI);
        check_output("lit release pc", pc_out, 32'hC);
        check_output("lit release ifid_pc", ifid_pc, 32'h8);
        check_output("lit release ifid_pc4", ifid_pc4, 32'hC);

        // Redirect beats stall, target aligned down
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, ADDI);
        apply_stimulus(0, 1, 1, 32'h23, ADDI);
        check_output("lit redirect pc", pc_out, 32'h20);
        check_output("lit redirect valid", {31'b0, ifid_valid}, 32'h0);
        check_output("lit redirect inst", ifid_inst, 32'h00000033);

        // Redirect beats halt detection
        apply_stimulus(0, 0, 1, 32'h10, HALT_WORD);
        check_output("lit redir-over-halt", {31'b0, halted}, 32'h0);

        // Halt at 0x10, then redirect and stall ignored
        apply_stimulus(0, 0, 0, 0, HALT_WORD);
        check_output("lit halt halted", {31'b0, halted}, 32'h1);
        check_output("lit halt pc", pc_out, 32'h10);
        apply_stimulus(0, 0, 1, 32'h40, ADDI);
        check_output("lit halt redirect ignored", pc_out, 32'h10);
        apply_stimulus(0, 1, 0, 0, ADDI);
        apply_stimulus(0, 0, 0, 0, ADDI);
        check_output("lit halt fetch ignored", pc_out, 32'h10);
        apply_stimulus(1, 0, 0, 0, ADDI);
        check_output("lit halt reset pc", pc_out, 32'h0);
        check_output("lit halt reset halted", {31'b0, halted}, 32'h0);

        // Wrap at top of address space
        apply_stimulus(0, 0, 1, 32'hFFFFFFFC, ADDI);
        apply_stimulus(0, 0, 0, 0, ADDI);
        check_output("lit wrap pc", pc_out, 32'h0);
        check_output("lit wrap ifid_pc", ifid_pc, 32'hFFFFFFFC);
        check_output("lit wrap ifid_pc4", ifid_pc4, 32'h0);

        // Reset during stall
        apply_stimulus(0, 0, 0, 0, ADDI);
        apply_stimulus(1, 1, 1, 32'h80, ADDI);
        check_output("lit reset mid-stall pc", pc_out, 32'h0);

        // Counter: 5 fetches, 1 stall, 1 redirect
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, ADDI + i);
        apply_stimulus(0, 1, 0, 0, ADDI);
        apply_stimulus(0, 0, 1, 32'h100, ADDI);
`ifdef FETCH_PERF_CNT_EN
        check_output("lit fetch_count", fetch_count, 32'd5);
`else
        check_output("lit fetch_count", fetch_count, 32'd0);
`endif
        apply_stimulus(0, 0, 0, 0, 32'h12345678);
        check_output("lit after-redirect ifid_inst", ifid_inst, 32'h12345678);
        check_output("lit after-redirect ifid_pc", ifid_pc, 32'h100);

        check_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
